// File: rtl/cpu_dma_arbiter.sv
// cpu_dma_arbiter: two-phase clock generator for the ag6502 core plus a
// CPU/DMA bus arbiter. The CPU is halted through rdy, and the bus is handed
// to DMA only once the core is frozen on a read cycle.
module cpu_dma_arbiter #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic             baseclk,
  input  logic             rst,
  input  logic             cpu_read,
  input  logic             dma_req,
  input  logic             cnt_clr,
  output logic             phi_0,
  output logic             phi_1,
  output logic             phi_2,
  output logic             cpu_rdy,
  output logic             dma_gnt,
  output logic             bus_sel,
  output logic             cyc_start,
  output logic [CNT_W-1:0] dma_cycles
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int H  = DIV / 2;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_A      = CW'(DIV - 2);
  localparam logic [CW-1:0] PHI1_END   = CW'(H - 2);
  localparam logic [CW-1:0] PHI2_START = CW'(H);
  localparam logic [CW-1:0] PHI2_END   = CW'(DIV - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phi_0_q, phi_0_d;
  logic             phi_1_q, phi_1_d;
  logic             phi_2_q, phi_2_d;
  logic             cyc_start_q, cyc_start_d;
  logic             cpu_rdy_q, cpu_rdy_d;
  logic [CNT_W-1:0] dma_cycles_q, dma_cycles_d;
  logic             at_a;
  logic             at_b;

  // Point A is the edge entering the last phase, point B the wrap to 0.
  assign at_a = (cnt_q == CNT_A);
  assign at_b = (cnt_q == CNT_LAST);

  // Next phase count and the clock decode of that count, so every clock
  // output comes straight from a flop and cannot glitch.
  always_comb begin
    cnt_d       = at_b ? '0 : cnt_q + CW'(1);
    phi_1_d     = (cnt_d <= PHI1_END);
    phi_2_d     = (cnt_d >= PHI2_START) && (cnt_d <= PHI2_END);
    phi_0_d     = (cnt_d >= PHI2_START);
    cyc_start_d = (cnt_d == '0);
  end

  // Arbitration: rdy follows the request at A, ownership changes only at B
  // and only toward DMA when the frozen cycle is a read.
  always_comb begin
    cpu_rdy_d    = cpu_rdy_q;
    state_d      = state_q;
    dma_cycles_d = dma_cycles_q;

    if (at_a) begin
      cpu_rdy_d = !dma_req;
    end

    if (at_b) begin
      case (state_q)
        IDLE:    if (!cpu_rdy_q && cpu_read) state_d = GRANT;
        GRANT:   if (cpu_rdy_q)              state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if ((state_d == GRANT) && (dma_cycles_q != '1)) begin
        dma_cycles_d = dma_cycles_q + CNT_W'(1);
      end
    end

    if (cnt_clr) begin
      dma_cycles_d = '0;
    end
  end

  // Phase counter and registered clock outputs; reset parks in the last
  // phase so the first edge after release starts a fresh CPU cycle.
  always_ff @(posedge baseclk or posedge rst) begin
    if (rst) begin
      cnt_q       <= CNT_LAST;
      phi_0_q     <= 1'b1;
      phi_1_q     <= 1'b0;
      phi_2_q     <= 1'b0;
      cyc_start_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phi_0_q     <= phi_0_d;
      phi_1_q     <= phi_1_d;
      phi_2_q     <= phi_2_d;
      cyc_start_q <= cyc_start_d;
    end
  end

  // Arbiter state, rdy and the granted-cycle counter.
  always_ff @(posedge baseclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cpu_rdy_q    <= 1'b1;
      dma_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_cycles_q <= dma_cycles_d;
    end
  end

  // The one-bit state encoding makes the grant a direct flop output.
  assign phi_0      = phi_0_q;
  assign phi_1      = phi_1_q;
  assign phi_2      = phi_2_q;
  assign cyc_start  = cyc_start_q;
  assign cpu_rdy    = cpu_rdy_q;
  assign dma_gnt    = (state_q == GRANT);
  assign bus_sel    = (state_q == GRANT);
  assign dma_cycles = dma_cycles_q;

endmodule

// File: tb/tb_cpu_dma_arbiter.sv
// tb_cpu_dma_arbiter: drives a DIV=4/CNT_W=4 arbiter and a DIV=6/CNT_W=16
// arbiter with shared inputs and checks both against a cycle-position model.
module tb_cpu_dma_arbiter;

  logic        baseclk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b1;
  logic        dma_req = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [1:0]  phi_0_w, phi_1_w, phi_2_w, cpu_rdy_w, dma_gnt_w, bus_sel_w, cyc_start_w;
  logic [3:0]  dc4;
  logic [15:0] dc6;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Model state per instance: position in the CPU cycle, rdy, owner, count.
  int m_div[2] = '{4, 6};
  int m_max[2] = '{15, 65535};
  int m_pos[2];
  bit m_rdy[2];
  bit m_gnt[2];
  int m_cyc[2];

  cpu_dma_arbiter #(.DIV(4), .CNT_W(4)) u_dut4 (
    .baseclk(baseclk), .rst(rst), .cpu_read(cpu_read), .dma_req(dma_req),
    .cnt_clr(cnt_clr), .phi_0(phi_0_w[0]), .phi_1(phi_1_w[0]), .phi_2(phi_2_w[0]),
    .cpu_rdy(cpu_rdy_w[0]), .dma_gnt(dma_gnt_w[0]), .bus_sel(bus_sel_w[0]),
    .cyc_start(cyc_start_w[0]), .dma_cycles(dc4)
  );

  cpu_dma_arbiter #(.DIV(6), .CNT_W(16)) u_dut6 (
    .baseclk(baseclk), .rst(rst), .cpu_read(cpu_read), .dma_req(dma_req),
    .cnt_clr(cnt_clr), .phi_0(phi_0_w[1]), .phi_1(phi_1_w[1]), .phi_2(phi_2_w[1]),
    .cpu_rdy(cpu_rdy_w[1]), .dma_gnt(dma_gnt_w[1]), .bus_sel(bus_sel_w[1]),
    .cyc_start(cyc_start_w[1]), .dma_cycles(dc6)
  );

  always #5 baseclk = ~baseclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic req, input logic clr);
    cpu_read = rd;
    dma_req  = req;
    cnt_clr  = clr;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = m_div[k] - 1;
      m_rdy[k] = 1'b1;
      m_gnt[k] = 1'b0;
      m_cyc[k] = 0;
    end
  endtask

  // Wait (bounded) until the DIV=4 model sits at phase position p.
  task automatic waitPos(input int p);
    bit hit = 0;
    for (int i = 0; i < 16 && !hit; i++) begin
      @(negedge baseclk);
      if (m_pos[0] == p) hit = 1;
    end
    if (!hit) checkOutput("waitPos_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: rdy follows the request one phase before the wrap; at
  // the wrap DMA owns the next cycle iff the CPU is halted and it is either
  // already DMA's cycle or the frozen cycle is a read.
  always @(posedge baseclk or posedge rst) begin : model
    bit next_gnt;
    if (rst) begin
      modelReset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_pos[k] == m_div[k] - 2) m_rdy[k] = !dma_req;
        if (m_pos[k] == m_div[k] - 1) begin
          next_gnt = !m_rdy[k] && (m_gnt[k] || cpu_read);
          m_gnt[k] = next_gnt;
          if (next_gnt && m_cyc[k] < m_max[k]) m_cyc[k] = m_cyc[k] + 1;
        end
        if (cnt_clr) m_cyc[k] = 0;
        m_pos[k] = (m_pos[k] + 1) % m_div[k];
      end
    end
  end

  // Every falling edge: all outputs of both instances against the model.
  always @(negedge baseclk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        int h;
        h = m_div[k] / 2;
        checkOutput($sformatf("phi_1[%0d]", k), 32'(phi_1_w[k]), 32'(m_pos[k] <= h - 2));
        checkOutput($sformatf("phi_2[%0d]", k), 32'(phi_2_w[k]),
                    32'(m_pos[k] >= h && m_pos[k] <= m_div[k] - 2));
        checkOutput($sformatf("phi_0[%0d]", k), 32'(phi_0_w[k]), 32'(m_pos[k] >= h));
        checkOutput($sformatf("cyc_start[%0d]", k), 32'(cyc_start_w[k]), 32'(m_pos[k] == 0));
        checkOutput($sformatf("phi_overlap[%0d]", k), 32'(phi_1_w[k] & phi_2_w[k]), 32'd0);
        checkOutput($sformatf("cpu_rdy[%0d]", k), 32'(cpu_rdy_w[k]), 32'(m_rdy[k]));
        checkOutput($sformatf("dma_gnt[%0d]", k), 32'(dma_gnt_w[k]), 32'(m_gnt[k]));
        checkOutput($sformatf("bus_sel[%0d]", k), 32'(bus_sel_w[k]), 32'(m_gnt[k]));
      end
      checkOutput("dma_cycles[0]", {28'd0, dc4}, 32'(m_cyc[0]));
      checkOutput("dma_cycles[1]", {16'd0, dc6}, 32'(m_cyc[1]));
    end
  end

  // Directed scenarios with literal expectations, then a random run.
  initial begin
    modelReset();
    started = 1;
    applyStimulus(1, 0, 0);
    #12;
    checkOutput("rst_phi_0", 32'(phi_0_w[0]), 32'd1);
    checkOutput("rst_phi_1", 32'(phi_1_w[0]), 32'd0);
    checkOutput("rst_cpu_rdy", 32'(cpu_rdy_w[0]), 32'd1);
    checkOutput("rst_dma_cycles", {28'd0, dc4}, 32'd0);
    @(negedge baseclk);
    rst = 1'b0;
    waitPos(0);
    checkOutput("first_cyc_start", 32'(cyc_start_w[0]), 32'd1);
    checkOutput("first_phi_1", 32'(phi_1_w[0]), 32'd1);

    // Read-cycle grant, hold for five cycles, release.
    waitPos(1);
    applyStimulus(1, 1, 0);
    waitPos(3);
    checkOutput("grant_rdy_low", 32'(cpu_rdy_w[0]), 32'd0);
    waitPos(0);
    checkOutput("grant_gnt", 32'(dma_gnt_w[0]), 32'd1);
    checkOutput("grant_bus_sel", 32'(bus_sel_w[0]), 32'd1);
    checkOutput("grant_count", {28'd0, dc4}, 32'd1);
    repeat (4) waitPos(0);
    waitPos(1);
    applyStimulus(1, 0, 0);
    waitPos(3);
    checkOutput("release_rdy", 32'(cpu_rdy_w[0]), 32'd1);
    waitPos(0);
    checkOutput("release_gnt", 32'(dma_gnt_w[0]), 32'd0);
    checkOutput("release_count", {28'd0, dc4}, 32'd5);

    // Three write cycles stall the grant until the first read.
    waitPos(1);
    applyStimulus(0, 1, 0);
    for (int w = 0; w < 3; w++) begin
      waitPos(0);
      checkOutput("stall_gnt", 32'(dma_gnt_w[0]), 32'd0);
      checkOutput("stall_rdy", 32'(cpu_rdy_w[0]), 32'd0);
    end
    applyStimulus(1, 1, 0);
    waitPos(0);
    checkOutput("stall_then_grant", 32'(dma_gnt_w[0]), 32'd1);
    waitPos(1);
    applyStimulus(1, 0, 0);
    waitPos(0);
    waitPos(0);
    checkOutput("stall_release", 32'(dma_gnt_w[0]), 32'd0);

    // Asynchronous reset in the middle of a granted cycle.
    waitPos(1);
    applyStimulus(1, 1, 0);
    waitPos(0);
    checkOutput("pre_reset_gnt", 32'(dma_gnt_w[0]), 32'd1);
    waitPos(2);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_gnt", 32'(dma_gnt_w[0]), 32'd0);
    checkOutput("midrst_bus_sel", 32'(bus_sel_w[0]), 32'd0);
    checkOutput("midrst_rdy", 32'(cpu_rdy_w[0]), 32'd1);
    checkOutput("midrst_phi_0", 32'(phi_0_w[0]), 32'd1);
    checkOutput("midrst_count", {28'd0, dc4}, 32'd0);
    applyStimulus(1, 0, 0);
    @(negedge baseclk);
    rst = 1'b0;
    waitPos(0);
    checkOutput("resume_phi_1", 32'(phi_1_w[0]), 32'd1);
    checkOutput("resume_cyc_start", 32'(cyc_start_w[0]), 32'd1);

    // Random traffic; the model is checked on every falling edge.
    for (int i = 0; i < 600; i++) begin
      @(negedge baseclk);
      if ($urandom_range(0, 5) == 0) dma_req = ~dma_req;
      cpu_read = ($urandom_range(0, 2) != 0);
      cnt_clr  = ($urandom_range(0, 30) == 0);
    end

    // Saturation of the 4-bit counter, then clear on a granting wrap.
    applyStimulus(1, 0, 1);
    @(negedge baseclk);
    applyStimulus(1, 1, 0);
    repeat (22 * 4) @(negedge baseclk);
    checkOutput("sat_count", {28'd0, dc4}, 32'd15);
    checkOutput("sat_gnt", 32'(dma_gnt_w[0]), 32'd1);
    waitPos(3);
    applyStimulus(1, 1, 1);
    waitPos(0);
    checkOutput("clr_on_grant", {28'd0, dc4}, 32'd0);
    checkOutput("clr_gnt_held", 32'(dma_gnt_w[0]), 32'd1);
    applyStimulus(1, 0, 0);
    repeat (12) @(negedge baseclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
